// File: rtl/unary_pkg.sv
// Shared types for the binary-to-unary stream generator.
package unary_pkg;

  typedef enum logic {
    UNARY_MODE_THERMO,
    UNARY_MODE_SPREAD
  } unary_mode_t;

  typedef enum logic {
    GEN_IDLE,
    GEN_STREAM
  } gen_state_t;

endpackage

// File: rtl/unary_spread_acc.sv
// Bresenham accumulator: emits v ones evenly spread over INPUT_WIDTH steps.
module unary_spread_acc #(
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   step,
  input  logic [COUNT_WIDTH-1:0] v,
  output logic                   spread_bit_c
);

  localparam int unsigned SUM_WIDTH = COUNT_WIDTH + 1;

  logic [COUNT_WIDTH-1:0] acc_q;
  logic [COUNT_WIDTH-1:0] acc_d;
  logic [SUM_WIDTH-1:0]   sum;
  logic [SUM_WIDTH-1:0]   wrapped;

  always_comb begin
    sum          = {1'b0, acc_q} + {1'b0, v};
    spread_bit_c = (sum >= SUM_WIDTH'(INPUT_WIDTH));
    wrapped      = spread_bit_c ? (sum - SUM_WIDTH'(INPUT_WIDTH)) : sum;
    acc_d        = acc_q;
    // clear wins so a back-to-back reload starts from zero
    if (clear) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = wrapped[COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/unary_stream_gen.sv
// Binary-to-unary source: accepts a magnitude, emits INPUT_WIDTH serial bits with that many ones.
module unary_stream_gen
  import unary_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] in_value,
  input  logic                   in_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   hold,
  output logic                   y,
  output logic                   valid,
  output logic                   last
);

  gen_state_t             state_q, state_d;
  unary_mode_t            mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] v_q, v_d;
  logic                   y_q, y_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;

  logic                   final_bit;
  logic                   issue;
  logic                   acc_clear;
  logic                   spread_bit_c;
  logic [COUNT_WIDTH-1:0] in_value_sat;

  assign final_bit    = (cnt_q == COUNT_WIDTH'(INPUT_WIDTH - 1));
  assign in_value_sat = (in_value > COUNT_WIDTH'(INPUT_WIDTH)) ? COUNT_WIDTH'(INPUT_WIDTH) : in_value;

  unary_spread_acc #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_spread_acc (
    .clk          (clk),
    .reset        (reset),
    .clear        (acc_clear),
    .step         (issue),
    .v            (v_q),
    .spread_bit_c (spread_bit_c)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    v_d       = v_q;
    y_d       = 1'b0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    in_ready  = 1'b0;
    issue     = 1'b0;
    acc_clear = 1'b0;

    case (state_q)
      GEN_IDLE: begin
        in_ready = 1'b1;
      end
      GEN_STREAM: begin
        if (!hold) begin
          issue   = 1'b1;
          valid_d = 1'b1;
          y_d     = (mode_q == UNARY_MODE_THERMO) ? (cnt_q < v_q) : spread_bit_c;
          last_d  = final_bit;
          cnt_d   = cnt_q + COUNT_WIDTH'(1);
          if (final_bit) begin
            in_ready = 1'b1;
            state_d  = GEN_IDLE;
          end
        end
      end
      default: state_d = GEN_IDLE;
    endcase

    // accepting on the final-bit cycle chains the next stream with no bubble
    if (in_valid && in_ready) begin
      v_d       = in_value_sat;
      mode_d    = unary_mode_t'(in_mode);
      cnt_d     = '0;
      acc_clear = 1'b1;
      state_d   = GEN_STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= GEN_IDLE;
      mode_q  <= UNARY_MODE_THERMO;
      cnt_q   <= '0;
      v_q     <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign last  = last_q;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Self-checking bench for unary_stream_gen against an arithmetic reference of the bit patterns.
module tb_unary_stream_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] in_value;
  logic          in_mode;
  logic          in_valid;
  logic          in_ready;
  logic          hold;
  logic          y;
  logic          valid;
  logic          last;

  int passed = 0;
  int total  = 0;

  unary_stream_gen #(.INPUT_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_value (in_value),
    .in_mode  (in_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hold     (hold),
    .y        (y),
    .valid    (valid),
    .last     (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input int obs, input int exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Thermometer: first v bits set. Spread: bit k set when floor((k+1)v/W) advances.
  function automatic int model_bit(input int v, input logic mode, input int k);
    if (!mode) return (k < v) ? 1 : 0;
    return (((k + 1) * v) / W != (k * v) / W) ? 1 : 0;
  endfunction

  function automatic int sat(input int v);
    return (v > int'(W)) ? int'(W) : v;
  endfunction

  // Present one value; caller must be at a negedge with the block idle.
  task automatic send(input int val, input logic mode, input string tag);
    in_value = CW'(val);
    in_mode  = mode;
    in_valid = 1'b1;
    #1;
    chk(int'(in_ready), 1, {tag, "_ready_at_accept"});
    @(negedge clk);
    in_valid = 1'b0;
    in_value = CW'($urandom_range(0, 15));
  endtask

  // Walk a stream bit by bit, optionally stalling, chaining a next value, or aborting via reset.
  task automatic collect(input int val, input logic mode, input int hold_at, input int hold_len,
                         input bit chain, input int chain_val, input logic chain_mode,
                         input int abort_at, input string tag);
    int v      = sat(val);
    int issued = 0;
    int held   = 0;
    int ones   = 0;
    int cyc    = 0;
    logic h;
    while (issued < int'(W)) begin
      if (cyc++ > 200) begin
        chk(issued, int'(W), {tag, "_timeout"});
        return;
      end
      if (issued == abort_at) begin
        reset = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        chk(int'(valid), 0, {tag, "_abort_valid"});
        chk(int'(last), 0, {tag, "_abort_last"});
        chk(int'(y), 0, {tag, "_abort_y"});
        chk(int'(in_ready), 1, {tag, "_abort_ready"});
        reset = 1'b1;
        return;
      end
      h = (issued == hold_at) && (held < hold_len);
      if (h) held++;
      hold = h;
      if (!h && issued == int'(W) - 1) begin
        in_valid = chain;
        in_value = CW'(chain_val);
        in_mode  = chain_mode;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_value = CW'($urandom_range(0, 15));
        in_mode  = 1'($urandom_range(0, 1));
      end
      #1;
      chk(int'(in_ready), (!h && issued == int'(W) - 1) ? 1 : 0, {tag, "_ready"});
      @(negedge clk);
      in_valid = 1'b0;
      hold     = 1'b0;
      if (h) begin
        chk(int'(valid), 0, {tag, "_hold_valid"});
        chk(int'(y) | int'(last), 0, {tag, "_hold_y_last"});
      end else begin
        chk(int'(valid), 1, {tag, "_valid"});
        chk(int'(y), model_bit(v, mode, issued), {tag, "_y"});
        chk(int'(last), (issued == int'(W) - 1) ? 1 : 0, {tag, "_last"});
        ones += int'(y);
        issued++;
      end
    end
    chk(ones, v, {tag, "_ones"});
    if (!chain) begin
      #1;
      chk(int'(in_ready), 1, {tag, "_ready_after"});
      @(negedge clk);
      chk(int'(valid), 0, {tag, "_idle_valid"});
    end
  endtask

  initial begin
    int rv;
    logic rm;
    reset    = 1'b0;
    in_value = '0;
    in_mode  = 1'b0;
    in_valid = 1'b0;
    hold     = 1'b0;
    repeat (2) @(negedge clk);
    chk(int'(y), 0, "rst_y");
    chk(int'(valid), 0, "rst_valid");
    chk(int'(last), 0, "rst_last");
    reset = 1'b1;
    #1;
    chk(int'(in_ready), 1, "rst_ready");
    @(negedge clk);

    send(3, 1'b0, "th3");  collect(3, 1'b0, -1, 0, 1'b0, 0, 1'b0, -1, "th3");
    send(3, 1'b1, "sp3");  collect(3, 1'b1, -1, 0, 1'b0, 0, 1'b0, -1, "sp3");
    send(0, 1'b0, "th0");  collect(0, 1'b0, -1, 0, 1'b0, 0, 1'b0, -1, "th0");
    send(0, 1'b1, "sp0");  collect(0, 1'b1, -1, 0, 1'b0, 0, 1'b0, -1, "sp0");
    send(8, 1'b0, "th8");  collect(8, 1'b0, -1, 0, 1'b0, 0, 1'b0, -1, "th8");
    send(8, 1'b1, "sp8");  collect(8, 1'b1, -1, 0, 1'b0, 0, 1'b0, -1, "sp8");
    send(12, 1'b0, "sat"); collect(12, 1'b0, -1, 0, 1'b0, 0, 1'b0, -1, "sat");
    send(5, 1'b1, "hold"); collect(5, 1'b1, 3, 2, 1'b0, 0, 1'b0, -1, "hold");

    send(6, 1'b0, "b2b_a");
    collect(6, 1'b0, -1, 0, 1'b1, 2, 1'b0, -1, "b2b_a");
    collect(2, 1'b0, -1, 0, 1'b0, 0, 1'b0, -1, "b2b_b");

    send(5, 1'b0, "abort"); collect(5, 1'b0, -1, 0, 1'b0, 0, 1'b0, 4, "abort");
    @(negedge clk);
    send(7, 1'b1, "fresh"); collect(7, 1'b1, -1, 0, 1'b0, 0, 1'b0, -1, "fresh");

    for (int i = 0; i < 8; i++) begin
      rv = int'($urandom_range(0, 15));
      rm = 1'($urandom_range(0, 1));
      send(rv, rm, "rand");
      collect(rv, rm, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)),
              1'b0, 0, 1'b0, -1, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
